runner_motion: RTL and testbench

RUNNER_MOTION -- requirements
Module: runner_motion

---
 rtl/runner_pkg.sv | 40 ++++
 rtl/key_edge_latch.sv | 38 +++
 rtl/runner_motion.sv | 182 ++++++++++++++++++
 tb/tb_runner_motion.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// Shared types and constants for the runner sprite motion block.
// Holds the FSM state encoding, sprite_sel codes, default physics
// constants and a helper that maps (state, leg phase) to a sprite code.
package runner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_JUMP = 3'd2,
    ST_DUCK = 3'd3,
    ST_DEAD = 3'd4
  } state_t;

  localparam logic [2:0] SPR_STAND  = 3'd0;
  localparam logic [2:0] SPR_RUN_A  = 3'd1;
  localparam logic [2:0] SPR_RUN_B  = 3'd2;
  localparam logic [2:0] SPR_DUCK_A = 3'd3;
  localparam logic [2:0] SPR_DUCK_B = 3'd4;
  localparam logic [2:0] SPR_DEAD   = 3'd5;

  localparam logic [9:0] DEF_RUNNER_X     = 10'd40;
  localparam logic [9:0] DEF_GROUND_Y     = 10'd300;
  localparam int         DEF_JUMP_V0      = 13;
  localparam int         DEF_GRAVITY      = 1;
  localparam int         DEF_FAST_GRAVITY = 3;
  localparam int         DEF_ANIM_DIV     = 6;

  function automatic logic [2:0] sprite_of(input state_t st, input logic leg);
    logic [2:0] spr;
    spr = SPR_STAND;
    case (st)
      ST_RUN:  spr = leg ? SPR_RUN_B  : SPR_RUN_A;
      ST_DUCK: spr = leg ? SPR_DUCK_B : SPR_DUCK_A;
      ST_DEAD: spr = SPR_DEAD;
      default: spr = SPR_STAND;
    endcase
    return spr;
  endfunction

endpackage

// File: rtl/key_edge_latch.sv
// Rising-edge detector with a sticky pending flag.
// A 0->1 transition of i_key sets o_pending on the following clock; the
// flag holds until i_consume clears it, so presses between frame ticks
// are never lost. The previous-key register resets to 1 so a key held
// through reset does not register as a press.
// Ports: i_clk, i_rst (sync, active-high), i_key (level), i_consume,
//        o_pending (registered flag).
module key_edge_latch (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_consume,
  output logic o_pending
);

  logic r_prev;
  logic r_pending;
  logic w_rise;

  assign w_rise = i_key & ~r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev    <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_prev <= i_key;
      // A fresh press wins over a same-cycle consume so it is not dropped.
      if (w_rise)
        r_pending <= 1'b1;
      else if (i_consume)
        r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/runner_motion.sv
// Runner sprite motion controller: jump physics, ducking, leg animation
// and death handling, advanced once per video frame tick.
// Ports: Clk50 (clock), Reset (sync, active-high), frame_tick (1-clock
//        pulse per frame), jump_key / duck_key / game_over (levels),
//        RunnerX / RunnerY (sprite origin), sprite_sel (sprite code),
//        running (1 in RUN, JUMP or DUCK). All outputs are registered.
//
// state | meaning
// IDLE  | standing on the ground before the first jump
// RUN   | on the ground, legs animating
// JUMP  | airborne, ballistic update every frame tick
// DUCK  | on the ground with duck key held, legs animating
// DEAD  | hit by an obstacle, frozen until a new jump press
module runner_motion
  import runner_pkg::*;
#(
  parameter logic [9:0] RUNNER_X     = DEF_RUNNER_X,
  parameter logic [9:0] GROUND_Y     = DEF_GROUND_Y,
  parameter int         JUMP_V0      = DEF_JUMP_V0,
  parameter int         GRAVITY      = DEF_GRAVITY,
  parameter int         FAST_GRAVITY = DEF_FAST_GRAVITY,
  parameter int         ANIM_DIV     = DEF_ANIM_DIV
) (
  input  logic       Clk50,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       jump_key,
  input  logic       duck_key,
  input  logic       game_over,
  output logic [9:0] RunnerX,
  output logic [9:0] RunnerY,
  output logic [2:0] sprite_sel,
  output logic       running
);

  localparam logic signed [6:0] VEL_LAUNCH = 7'(-JUMP_V0);
  localparam logic [7:0]        ANIM_LAST  = 8'(ANIM_DIV - 1);

  state_t            r_state;
  logic [9:0]        r_y;
  logic signed [6:0] r_vel;
  logic [7:0]        r_anim_cnt;
  logic              r_leg;
  logic [2:0]        r_sprite;
  logic              r_running;

  logic               w_pending;
  logic               w_consume;
  logic               w_hit;
  logic signed [11:0] w_y_sum;
  logic               w_land;
  logic [9:0]         w_y_air;
  logic signed [7:0]  w_grav;
  logic signed [7:0]  w_vel_sum;
  logic signed [6:0]  w_vel_nxt;
  logic               w_anim_wrap;
  logic [7:0]         w_anim_nxt;
  logic               w_leg_nxt;

  // The flag is consumed on every tick except when game_over blocks the
  // tick's transition (DEAD entry, or staying DEAD), so a press made
  // while dead survives until the collision clears.
  assign w_consume = frame_tick & ~(game_over & (r_state != ST_IDLE));

  key_edge_latch u_jump_latch (
    .i_clk     (Clk50),
    .i_rst     (Reset),
    .i_key     (jump_key),
    .i_consume (w_consume),
    .o_pending (w_pending)
  );

  assign w_hit = game_over &
                 ((r_state == ST_RUN) | (r_state == ST_JUMP) | (r_state == ST_DUCK));

  assign w_y_sum = $signed({2'b00, r_y}) + $signed({{5{r_vel[6]}}, r_vel});
  assign w_land  = (w_y_sum >= $signed({2'b00, GROUND_Y}));
  assign w_y_air = w_y_sum[11] ? 10'd0 : w_y_sum[9:0];

  assign w_grav    = duck_key ? 8'(FAST_GRAVITY) : 8'(GRAVITY);
  assign w_vel_sum = {r_vel[6], r_vel} + w_grav;
  assign w_vel_nxt = (w_vel_sum > 8'sd63) ? 7'sd63 : w_vel_sum[6:0];

  assign w_anim_wrap = (r_anim_cnt == ANIM_LAST);
  assign w_anim_nxt  = w_anim_wrap ? 8'd0 : r_anim_cnt + 8'd1;
  assign w_leg_nxt   = r_leg ^ w_anim_wrap;

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_y        <= GROUND_Y;
      r_vel      <= '0;
      r_anim_cnt <= '0;
      r_leg      <= 1'b0;
      r_sprite   <= SPR_STAND;
      r_running  <= 1'b0;
    end else if (w_hit) begin
      // Death is taken immediately, not at the next frame; position freezes.
      r_state    <= ST_DEAD;
      r_anim_cnt <= '0;
      r_leg      <= 1'b0;
      r_sprite   <= SPR_DEAD;
      r_running  <= 1'b0;
    end else if (frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state   <= ST_JUMP;
            r_vel     <= VEL_LAUNCH;
            r_sprite  <= SPR_STAND;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_pending) begin
            r_state    <= ST_JUMP;
            r_vel      <= VEL_LAUNCH;
            r_anim_cnt <= '0;
            r_leg      <= 1'b0;
            r_sprite   <= SPR_STAND;
          end else if (duck_key) begin
            r_state    <= ST_DUCK;
            r_anim_cnt <= '0;
            r_leg      <= 1'b0;
            r_sprite   <= SPR_DUCK_A;
          end else begin
            r_anim_cnt <= w_anim_nxt;
            r_leg      <= w_leg_nxt;
            r_sprite   <= sprite_of(ST_RUN, w_leg_nxt);
          end
        end
        ST_DUCK: begin
          if (!duck_key) begin
            r_state    <= ST_RUN;
            r_anim_cnt <= '0;
            r_leg      <= 1'b0;
            r_sprite   <= SPR_RUN_A;
          end else begin
            r_anim_cnt <= w_anim_nxt;
            r_leg      <= w_leg_nxt;
            r_sprite   <= sprite_of(ST_DUCK, w_leg_nxt);
          end
        end
        ST_JUMP: begin
          if (w_land) begin
            r_y        <= GROUND_Y;
            r_vel      <= '0;
            r_state    <= duck_key ? ST_DUCK : ST_RUN;
            r_anim_cnt <= '0;
            r_leg      <= 1'b0;
            r_sprite   <= duck_key ? SPR_DUCK_A : SPR_RUN_A;
          end else begin
            r_y   <= w_y_air;
            r_vel <= w_vel_nxt;
          end
        end
        ST_DEAD: begin
          if (w_pending && !game_over) begin
            r_state    <= ST_RUN;
            r_y        <= GROUND_Y;
            r_vel      <= '0;
            r_anim_cnt <= '0;
            r_leg      <= 1'b0;
            r_sprite   <= SPR_RUN_A;
            r_running  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_sprite  <= SPR_STAND;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign RunnerX    = RUNNER_X;
  assign RunnerY    = r_y;
  assign sprite_sel = r_sprite;
  assign running    = r_running;

endmodule

// File: tb/tb_runner_motion.sv
// Scoreboard bench for runner_motion: a per-clock behavioural model
// predicts the registered outputs, the driver queues each prediction and
// an independent monitor compares them one clock later.
module tb_runner_motion;

  localparam int GROUND = 300;
  localparam int V0     = 13;
  localparam int G_N    = 1;
  localparam int G_F    = 3;
  localparam int ADIV   = 6;

  localparam int M_IDLE = 0, M_RUN = 1, M_JUMP = 2, M_DUCK = 3, M_DEAD = 4;

  logic       Clk50 = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_key = 1'b0;
  logic       duck_key = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] RunnerX;
  logic [9:0] RunnerY;
  logic [2:0] sprite_sel;
  logic       running;

  runner_motion dut (
    .Clk50      (Clk50),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .jump_key   (jump_key),
    .duck_key   (duck_key),
    .game_over  (game_over),
    .RunnerX    (RunnerX),
    .RunnerY    (RunnerY),
    .sprite_sel (sprite_sel),
    .running    (running)
  );

  always #10 Clk50 = ~Clk50;

  typedef struct {
    int y;
    int spr;
    int run;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position, velocity, pending press, ticks spent in
  // the current ground state (legs swap every ADIV of those ticks).
  int m_st = M_IDLE, m_y = GROUND, m_v = 0, m_ticks = 0;
  bit m_pend = 0, m_prev = 1;
  bit dk_g = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input bit tk, input bit jk,
                                     input bit dk, input bit go);
    int  old;
    int  ny;
    bit  rise;
    bit  used;
    if (rst) begin
      m_st = M_IDLE; m_y = GROUND; m_v = 0; m_pend = 0; m_prev = 1; m_ticks = 0;
      return;
    end
    rise   = jk && !m_prev;
    m_prev = jk;
    old    = m_st;
    used   = tk && !(go && old != M_IDLE);
    if (go && (m_st == M_RUN || m_st == M_JUMP || m_st == M_DUCK)) begin
      m_st = M_DEAD;
    end else if (tk) begin
      case (m_st)
        M_IDLE: if (m_pend) begin m_st = M_JUMP; m_v = -V0; end
        M_RUN: begin
          if (m_pend) begin m_st = M_JUMP; m_v = -V0; end
          else if (dk) m_st = M_DUCK;
          else m_ticks++;
        end
        M_DUCK: if (!dk) m_st = M_RUN; else m_ticks++;
        M_JUMP: begin
          ny = m_y + m_v;
          if (ny >= GROUND) begin
            m_y = GROUND; m_v = 0; m_st = dk ? M_DUCK : M_RUN;
          end else begin
            m_y = (ny < 0) ? 0 : ny;
            m_v = m_v + (dk ? G_F : G_N);
            if (m_v > 63) m_v = 63;
          end
        end
        M_DEAD: if (m_pend && !go) begin m_st = M_RUN; m_y = GROUND; m_v = 0; end
        default: m_st = M_IDLE;
      endcase
    end
    if (rise) m_pend = 1;
    else if (used) m_pend = 0;
    if (m_st != old) m_ticks = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   leg;
    leg   = (m_ticks / ADIV) % 2;
    e.y   = m_y;
    e.run = (m_st == M_RUN || m_st == M_JUMP || m_st == M_DUCK) ? 1 : 0;
    case (m_st)
      M_RUN:   e.spr = 1 + leg;
      M_DUCK:  e.spr = 3 + leg;
      M_DEAD:  e.spr = 5;
      default: e.spr = 0;
    endcase
    return e;
  endfunction

  task automatic cyc(input bit rst, input bit tk, input bit jk, input bit dk, input bit go);
    @(negedge Clk50);
    Reset = rst; frame_tick = tk; jump_key = jk; duck_key = dk; game_over = go;
    model_step(rst, tk, jk, dk, go);
    q.push_back(model_out());
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, dk_g, 0);
      cyc(0, 0, 0, dk_g, 0);
      cyc(0, 0, 0, dk_g, 0);
    end
  endtask

  task automatic pulse_jump();
    cyc(0, 0, 1, dk_g, 0);
    cyc(0, 0, 0, dk_g, 0);
  endtask

  task automatic after_edge();
    @(posedge Clk50);
    #2;
  endtask

  // Monitor: every clock the DUT presents new registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk50);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_runner_y", int'(RunnerY), e.y);
        chk("mon_sprite_sel", int'(sprite_sel), e.spr);
        chk("mon_running", int'(running), e.run);
        chk("mon_runner_x", int'(RunnerX), 40);
      end
    end
  end

  initial begin
    int ey;
    int n;
    bit jk_r, dk_r, go_r, rst_r, tk_r;

    // Reset with jump key already held.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 1);
    after_edge();
    chk("reset_y", int'(RunnerY), 300);
    chk("reset_sprite", int'(sprite_sel), 0);
    chk("reset_running", int'(running), 0);

    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    after_edge();
    chk("held_key_no_jump", int'(running), 0);
    cyc(0, 0, 0, 0, 0);

    // Full jump: launch tick + 13 rising ticks reaches the apex.
    pulse_jump();
    tick(14);
    after_edge();
    chk("apex_y", int'(RunnerY), 209);
    tick(14);
    after_edge();
    chk("landed_y", int'(RunnerY), 300);
    chk("landed_running", int'(running), 1);
    chk("landed_sprite_run", int'(sprite_sel == 3'd1 || sprite_sel == 3'd2), 1);

    // Leg animation in RUN.
    tick(5);
    after_edge();
    chk("run_leg_a", int'(sprite_sel), 1);
    tick(1);
    after_edge();
    chk("run_leg_b", int'(sprite_sel), 2);
    dk_g = 1;
    tick(1);
    after_edge();
    chk("duck_sprite", int'(sprite_sel), 3);

    // Fast-fall jump ending in DUCK.
    dk_g = 0;
    tick(1);
    pulse_jump();
    tick(4);
    dk_g = 1;
    n = 0;
    while (m_st == M_JUMP && n < 60) begin
      tick(1);
      n++;
    end
    chk("fastfall_bounded", int'(n < 60), 1);
    after_edge();
    chk("fastfall_land_y", int'(RunnerY), 300);
    chk("fastfall_duck_sprite", int'(sprite_sel), 3);

    // Death between ticks mid-jump, then revival.
    dk_g = 0;
    tick(1);
    pulse_jump();
    tick(4);
    ey = m_y;
    cyc(0, 0, 0, 0, 1);
    after_edge();
    chk("dead_sprite", int'(sprite_sel), 5);
    chk("dead_y_frozen", int'(RunnerY), ey);
    chk("dead_running", int'(running), 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    pulse_jump();
    tick(1);
    after_edge();
    chk("revive_y", int'(RunnerY), 300);
    chk("revive_sprite", int'(sprite_sel), 1);

    // Reset mid-jump overrides tick and game_over.
    pulse_jump();
    tick(5);
    cyc(1, 1, 0, 0, 1);
    after_edge();
    chk("midjump_reset_y", int'(RunnerY), 300);
    chk("midjump_reset_sprite", int'(sprite_sel), 0);
    chk("midjump_reset_running", int'(running), 0);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic.
    jk_r = 0; dk_r = 0; go_r = 0;
    for (int i = 0; i < 8000; i++) begin
      rst_r = ($urandom_range(0, 1999) == 0);
      tk_r  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)  jk_r = ~jk_r;
      if ($urandom_range(0, 39) == 0) dk_r = ~dk_r;
      if (go_r) begin
        if ($urandom_range(0, 9) == 0) go_r = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        go_r = 1;
      end
      cyc(rst_r, tk_r, jk_r, dk_r, go_r);
    end
    cyc(0, 0, 0, 0, 0);

    repeat (3) @(posedge Clk50);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
